// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 host-side blocks.
//   ps2_tx_state_t  - transmitter FSM state encoding
//   PS2_FRAME_BITS  - bits on the wire per host->device frame (start..stop)
//   odd_parity()    - PS/2 parity bit for a data byte
//   PS2_CMD_*       - common keyboard command bytes
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    REQ     = 3'd2,
    SEND    = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5,
    DONE    = 3'd6
  } ps2_tx_state_t;

  localparam int unsigned PS2_FRAME_BITS = 11;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

  // Parity bit making the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, status and pin signals of ps2_host_tx.
//   tx_valid/tx_data/tx_ready - command byte handshake
//   busy/done/ack_ok/error    - transfer status
//   ps2_clk_i/ps2_data_i      - raw pin levels (asynchronous)
//   ps2_clk_oe/ps2_data_oe    - 1 = pull the open-collector line low
// master: command source plus pin pads; slave: the transmitter.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_ok;
  logic       error;
  logic       ps2_clk_i;
  logic       ps2_data_i;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;

  modport master (
    output tx_valid, tx_data, ps2_clk_i, ps2_data_i,
    input  tx_ready, busy, done, ack_ok, error, ps2_clk_oe, ps2_data_oe
  );

  modport slave (
    input  tx_valid, tx_data, ps2_clk_i, ps2_data_i,
    output tx_ready, busy, done, ack_ok, error, ps2_clk_oe, ps2_data_oe
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: brings the asynchronous PS/2 pin levels into the clk domain.
//   clk, resetn - system clock, async active-low reset
//   ps2_clk_i   - raw ps2_clk pin level
//   ps2_data_i  - raw ps2_data pin level
//   clk_s       - 2-FF synchronized ps2_clk
//   data_s      - 2-FF synchronized ps2_data
//   clk_fall    - one-cycle strobe on a falling edge of clk_s
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  // [1:0] are the synchronizer stages, [2] is the previous synchronized value.
  logic [2:0] clk_sh_q, clk_sh_d;
  logic [1:0] data_sh_q, data_sh_d;

  always_comb begin
    clk_sh_d  = {clk_sh_q[1:0], ps2_clk_i};
    data_sh_d = {data_sh_q[0], ps2_data_i};
  end

  // Idle bus level is high, so reset the stages high to avoid a false edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sh_q  <= '1;
      data_sh_q <= '1;
    end else begin
      clk_sh_q  <= clk_sh_d;
      data_sh_q <= data_sh_d;
    end
  end

  assign clk_s    = clk_sh_q[1];
  assign data_s   = data_sh_q[1];
  assign clk_fall = clk_sh_q[2] & ~clk_sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//   clk, resetn - system clock, async active-low reset
//   bus (slave) - tx_valid/tx_data/tx_ready handshake, busy/done/ack_ok/error
//                 status, ps2 pin levels in and pull-low enables out
// Sequence: inhibit clock, request-to-send, shift {stop,parity,data} out on
// device clock falling edges, sample the ACK slot, wait for bus release.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic           clk,
  input logic           resetn,
  ps2_host_tx_if.slave  bus
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam int unsigned SR_BITS = PS2_FRAME_BITS - 1;   // start bit is not stored
  localparam logic [3:0]  IDX_LAST = 4'(SR_BITS - 1);

  logic clk_s, data_s, clk_fall;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk_i  (bus.ps2_clk_i),
    .ps2_data_i (bus.ps2_data_i),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fall   (clk_fall)
  );

  ps2_tx_state_t        state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [SR_BITS-1:0]   frame_q, frame_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ack_ok_q, ack_ok_d;
  logic                 error_q, error_d;
  logic                 timeout;

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ack_ok_d  = ack_ok_q;
    error_d   = error_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.tx_valid && ready_q) begin
          frame_d  = {1'b1, odd_parity(bus.tx_data), bus.tx_data};
          idx_d    = '0;
          clk_oe_d = 1'b1;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
          ack_ok_d = 1'b0;
          error_d  = 1'b0;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          data_oe_d = 1'b1;                 // start bit, clock still held low
          cnt_d     = '0;
          state_d   = REQ;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      REQ: begin
        clk_oe_d = 1'b0;                    // hand the clock to the device
        cnt_d    = '0;
        state_d  = SEND;
      end

      SEND: begin
        if (clk_fall) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          cnt_d     = '0;
          if (idx_q == IDX_LAST) state_d = ACK;
        end else if (timeout) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ACK: begin
        if (clk_fall) begin
          ack_ok_d = ~data_s;
          cnt_d    = '0;
          state_d  = RELEASE;
        end else if (timeout) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      RELEASE: begin
        if (clk_s && data_s) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (timeout) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      DONE: begin
        cnt_d   = '0;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Timeout abort: any waiting state that jumped to DONE without a normal exit.
    if (timeout && !clk_fall && (state_q == SEND || state_q == ACK ||
        (state_q == RELEASE && !(clk_s && data_s)))) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      ack_ok_d  = 1'b0;
      error_d   = 1'b1;
      done_d    = 1'b1;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ack_ok_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ack_ok_q  <= ack_ok_d;
      error_q   <= error_d;
    end
  end

  assign bus.tx_ready    = ready_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.ack_ok      = ack_ok_q;
  assign bus.error       = error_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-collector
// keyboard model that clocks the frame, captures bits and optionally ACKs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH = 5000;
  localparam int unsigned TO  = 2000;
  localparam int unsigned H   = 25;     // device clock half-period in clk cycles

  typedef struct {
    logic [7:0] data;
    bit         ack;       // device pulls data low in the ACK slot
    logic       par;       // hand-computed odd parity bit
    logic       exp_ack;   // expected ack_ok at done
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if bus();

  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  assign bus.ps2_clk_i  = ~(bus.ps2_clk_oe  | dev_clk_low);
  assign bus.ps2_data_i = ~(bus.ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Passive monitors: done pulse count and length of the last clk_oe high run.
  int done_cnt = 0;
  int hi_run = 0;
  int last_hi = 0;
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.ps2_clk_oe === 1'b1) hi_run++;
    else if (hi_run != 0) begin
      last_hi = hi_run;
      hi_run = 0;
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (bus.tx_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", {31'b0, bus.tx_ready}, 32'd1);
  endtask

  task automatic send_start(input logic [7:0] d);
    @(negedge clk);
    wait_ready();
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("accept_ready", {31'b0, bus.tx_ready},   32'd0);
    chk("accept_busy",  {31'b0, bus.busy},       32'd1);
    chk("accept_clkoe", {31'b0, bus.ps2_clk_oe}, 32'd1);
  endtask

  // Device side: wait for request-to-send, then generate n_falls clock pulses.
  // The bit is read at the end of each high phase, before the next falling edge.
  task automatic dev_xfer(input bit ack, input int n_falls,
                          output logic [10:0] bits, output bit ok);
    int w = 0;
    ok   = 1'b0;
    bits = '0;
    while (!(bus.ps2_clk_i === 1'b1 && bus.ps2_data_i === 1'b0) && w < 8000) begin
      @(negedge clk);
      w++;
    end
    if (w < 8000) begin
      for (int k = 0; k < n_falls; k++) begin
        repeat (H) @(negedge clk);
        bits[k] = bus.ps2_data_i;
        if (k == 10 && ack) begin
          dev_data_low = 1'b1;
          repeat (5) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k == 10) dev_data_low = 1'b0;
      end
      ok = 1'b1;
    end
  endtask

  task automatic wait_done(output bit seen, output logic ack, output logic err);
    seen = 1'b0;
    ack  = 1'bx;
    err  = 1'bx;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        ack  = bus.ack_ok;
        err  = bus.error;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [10:0] bits;
    bit ok, seen;
    logic a, e;
    send_start(v.data);
    dev_xfer(v.ack, 11, bits, ok);
    chk("rts_seen", {31'b0, ok}, 32'd1);
    chk("frame", {21'b0, bits}, {21'b0, 1'b1, v.par, v.data, 1'b0});
    wait_done(seen, a, e);
    chk("done_seen", {31'b0, seen}, 32'd1);
    chk("ack_ok", {31'b0, a}, {31'b0, v.exp_ack});
    chk("error", {31'b0, e}, 32'd0);
    @(negedge clk);
    chk("ready_after", {31'b0, bus.tx_ready}, 32'd1);
    chk("ack_hold", {31'b0, bus.ack_ok}, {31'b0, v.exp_ack});
    chk("clk_oe_hi", last_hi, INH + 1);
  endtask

  vec_t vecs[5];

  initial begin
    logic [10:0] bits;
    bit ok, seen;
    logic a, e;
    int w, dc;

    // 0xED has six ones, 0x07 has three: odd parity gives 1 and 0.
    vecs[0] = '{data: PS2_CMD_SET_LED, ack: 1'b1, par: 1'b1, exp_ack: 1'b1};
    vecs[1] = '{data: 8'h00,           ack: 1'b1, par: 1'b1, exp_ack: 1'b1};
    vecs[2] = '{data: PS2_CMD_RESET,   ack: 1'b1, par: 1'b1, exp_ack: 1'b1};
    vecs[3] = '{data: 8'h07,           ack: 1'b1, par: 1'b0, exp_ack: 1'b1};
    vecs[4] = '{data: PS2_CMD_SET_LED, ack: 1'b0, par: 1'b1, exp_ack: 1'b0};

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  {31'b0, bus.tx_ready},    32'd1);
    chk("rst_busy",   {31'b0, bus.busy},        32'd0);
    chk("rst_clkoe",  {31'b0, bus.ps2_clk_oe},  32'd0);
    chk("rst_dataoe", {31'b0, bus.ps2_data_oe}, 32'd0);
    chk("rst_done",   {31'b0, bus.done},        32'd0);
    chk("rst_ack",    {31'b0, bus.ack_ok},      32'd0);
    chk("rst_err",    {31'b0, bus.error},       32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Device never clocks: abort exactly TO cycles after SEND entry.
    send_start(8'h12);
    w = 0;
    while (bus.ps2_clk_oe === 1'b1 && w < 6000) begin
      @(negedge clk);
      w++;
    end
    chk("to_send_entry", {31'b0, bus.ps2_clk_oe}, 32'd0);
    repeat (TO - 1) @(negedge clk);
    chk("to_pre_done",   {31'b0, bus.done},        32'd0);
    chk("to_pre_dataoe", {31'b0, bus.ps2_data_oe}, 32'd1);
    @(negedge clk);
    chk("to_done",   {31'b0, bus.done},        32'd1);
    chk("to_error",  {31'b0, bus.error},       32'd1);
    chk("to_ack",    {31'b0, bus.ack_ok},      32'd0);
    chk("to_clkoe",  {31'b0, bus.ps2_clk_oe},  32'd0);
    chk("to_dataoe", {31'b0, bus.ps2_data_oe}, 32'd0);
    @(negedge clk);
    chk("to_ready", {31'b0, bus.tx_ready}, 32'd1);

    // Reset after edge 4 of 0xF0: data bit 3 is 0, so data is being pulled low.
    send_start(8'hF0);
    dev_xfer(1'b0, 4, bits, ok);
    chk("rst_rts_seen", {31'b0, ok}, 32'd1);
    chk("rst_pre_dataoe", {31'b0, bus.ps2_data_oe}, 32'd1);
    dc = done_cnt;
    resetn = 1'b0;
    #1;
    chk("rst_mid_dataoe", {31'b0, bus.ps2_data_oe}, 32'd0);
    chk("rst_mid_clkoe",  {31'b0, bus.ps2_clk_oe},  32'd0);
    chk("rst_mid_ready",  {31'b0, bus.tx_ready},    32'd1);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (100) @(negedge clk);
    #1;
    chk("rst_no_done", done_cnt, dc);
    chk("rst_ready_after", {31'b0, bus.tx_ready}, 32'd1);
    run_vec(vecs[2]);

    // tx_valid held through a 0xED transfer with 0x55 queued behind it.
    @(negedge clk);
    wait_ready();
    bus.tx_valid = 1'b1;
    bus.tx_data  = PS2_CMD_SET_LED;
    @(negedge clk);
    chk("hold_accept", {31'b0, bus.tx_ready}, 32'd0);
    bus.tx_data = 8'h55;
    dev_xfer(1'b1, 11, bits, ok);
    chk("hold_frame_ed", {21'b0, bits}, {21'b0, 1'b1, 1'b1, PS2_CMD_SET_LED, 1'b0});
    wait_done(seen, a, e);
    chk("hold_done", {31'b0, seen}, 32'd1);
    chk("hold_ack",  {31'b0, a},    32'd1);
    chk("hold_clk_oe_hi", last_hi, INH + 1);
    @(negedge clk);
    chk("hold_ready_once", {31'b0, bus.tx_ready}, 32'd1);
    @(negedge clk);
    chk("hold_accept2", {31'b0, bus.tx_ready},   32'd0);
    chk("hold_clkoe2",  {31'b0, bus.ps2_clk_oe}, 32'd1);
    bus.tx_valid = 1'b0;
    dev_xfer(1'b1, 11, bits, ok);
    // 0x55 has four ones: parity 1.
    chk("hold_frame_55", {21'b0, bits}, {21'b0, 1'b1, 1'b1, 8'h55, 1'b0});
    wait_done(seen, a, e);
    chk("hold_done2", {31'b0, seen}, 32'd1);
    chk("hold_ack2",  {31'b0, a},    32'd1);
    chk("hold_err2",  {31'b0, e},    32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
